word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter IN_W, default 8, width of one input lane (LVDS byte).
REQ-002 SHALL have parameter RATIO, default 4, lanes per output word (legal 2..16).
REQ-003 SHALL have parameter TIMEOUT, default 0, idle cycles before auto-flush of a partial word (0 = disabled).
REQ-004 SHALL have parameter MSB_FIRST, default 0, 0 = first lane in bits [IN_W-1:0], 1 = first lane in top lane.
REQ-005 SHALL derive OUT_W = IN_W*RATIO and CW = clog2(RATIO+1) internally.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  in_data holds a lane this cycle; source cannot be stalled.
REQ-009 in_data  input  IN_W  lane data.
REQ-010 flush  input  1  one-cycle request to emit any partial word.
REQ-011 out_valid  output  1  out_data/out_count valid toward FIFO.
REQ-012 out_ready  input  1  FIFO accepts word when out_valid & out_ready.
REQ-013 out_data  output  OUT_W  packed word; unfilled lanes zero.
REQ-014 out_count  output  CW  number of valid lanes in out_data (1..RATIO).
REQ-015 overflow  output  1  sticky: at least one lane dropped.
REQ-016 drop_cnt  output  16  dropped-lane count, saturating at 0xFFFF.
REQ-017 clr_ovf  input  1  clears overflow and drop_cnt.

Function
REQ-018 SHALL hold two stages: accumulator (lanes + fill count 0..RATIO) and output register (out_valid/out_data/out_count).
REQ-019 Accepted lane k (0-based fill) SHALL land in lane slot k (MSB_FIRST=0) or RATIO-1-k (MSB_FIRST=1).
REQ-020 Output register is "free" when out_valid=0 or out_ready=1 in that cycle.
REQ-021 Lane completing fill=RATIO at edge N while output free SHALL give out_valid=1, out_count=RATIO at N+1; accumulator fill returns to 0 (one-cycle latency, back-to-back words at full input rate).
REQ-022 If output not free when accumulator completes, word SHALL stay in accumulator (fill=RATIO) and transfer on the first free cycle.
REQ-023 in_valid while accumulator fill=RATIO and output not free SHALL drop the lane: overflow<=1, drop_cnt+1 (saturating); accumulator unchanged.
REQ-024 in_valid on the transfer cycle of a held full word SHALL be accepted as lane 0 of the next word (no drop).
REQ-025 flush with fill>0 and output free SHALL move the partial word out with out_count=fill, unused lanes zero; flush with fill=0 SHALL do nothing.
REQ-026 flush and in_valid same cycle: lane SHALL be included first, then flushed (out_count=fill+1, or full word if that lane completes it).
REQ-027 flush while output not free SHALL be remembered (pending) and executed on the first free cycle; new lanes before then still accumulate.
REQ-028 TIMEOUT>0: idle counter SHALL count cycles with in_valid=0 and 0<fill<RATIO; reaching TIMEOUT SHALL act as flush; any in_valid or emit SHALL clear it.
REQ-029 out_data/out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 clr_ovf SHALL take priority over a same-cycle drop (result overflow=0, drop_cnt=0).

Reset
REQ-031 rst SHALL asynchronously force out_valid=0, out_data=0, out_count=0, overflow=0, drop_cnt=0, fill=0, pending flush=0, idle counter=0.
REQ-032 First lane after rst deassertion SHALL be lane 0; partial word at reset SHALL be discarded, never emitted.

Verification
REQ-033 Defaults, out_ready=1, lanes 0x11,0x22,0x33,0x44 consecutive -> one cycle later out_data=0x44332211, out_count=4, out_valid for one cycle.
REQ-034 MSB_FIRST=1, same lanes -> out_data=0x11223344.
REQ-035 Lanes 0xAA,0xBB then flush with 0xCC same cycle -> out_data=0x00CCBBAA, out_count=3.
REQ-036 out_ready=0, 9 consecutive lanes -> word 1 held, word 2 held in accumulator, lane 9 dropped: overflow=1, drop_cnt=1; out_ready=1 releases both words in order.
REQ-037 TIMEOUT=5, one lane 0x5A then idle -> partial word 0x0000005A, out_count=1, out_valid on the 6th cycle after the lane.
REQ-038 rst pulse mid-word after 2 lanes, then 4 lanes 0x01..0x04 -> out_data=0x04030201, no partial word emitted.

Source files
------------

// File: rtl/word_packer.sv
// Packs narrow input lanes into wide words for a FIFO. The input cannot be stalled,
// so a full word that cannot move on causes later lanes to be dropped and counted.
module word_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int TIMEOUT   = 0,
    parameter int MSB_FIRST = 0,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CW       = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    input  logic             clr_ovf
);

    // Output handshake: a word transfers on any cycle where out_valid and out_ready are
    // both high; out_data/out_count stay frozen while out_valid is high and out_ready low.

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic             pend_q, pend_d;
    logic [31:0]      idle_q, idle_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      drop_q, drop_d;

    logic             free, full, drop, emit, do_flush, timeout_hit;
    logic [OUT_W-1:0] acc_n;
    logic [CW-1:0]    fill_n;

    function automatic logic [OUT_W-1:0] place(input logic [OUT_W-1:0] w, input int k,
                                               input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] r;
        int s;
        r = w;
        s = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
        r[s*IN_W +: IN_W] = d;
        return r;
    endfunction

    always_comb begin
        free        = !out_valid_q || out_ready;
        full        = (fill_q == CW'(RATIO));
        timeout_hit = (TIMEOUT > 0) && !in_valid && (fill_q != '0) && !full &&
                      (idle_q == 32'(TIMEOUT - 1));
        acc_d       = acc_q;
        fill_d      = fill_q;
        pend_d      = pend_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        drop        = 1'b0;
        emit        = 1'b0;
        do_flush    = flush || pend_q || timeout_hit;
        acc_n       = in_valid ? place(acc_q, int'(fill_q), in_data) : acc_q;
        fill_n      = fill_q + CW'(in_valid);

        if (full) begin
            if (free) begin
                // Held word leaves; a lane arriving now starts the next word.
                emit        = 1'b1;
                out_data_d  = acc_q;
                out_count_d = CW'(RATIO);
                acc_d       = in_valid ? place('0, 0, in_data) : '0;
                fill_d      = CW'(in_valid);
                pend_d      = flush && in_valid;
            end else begin
                drop = in_valid;
                if (flush) pend_d = 1'b1;
            end
        end else begin
            acc_d  = acc_n;
            fill_d = fill_n;
            if ((fill_n != '0) && ((fill_n == CW'(RATIO)) || do_flush)) begin
                if (free) begin
                    emit        = 1'b1;
                    out_data_d  = acc_n;
                    out_count_d = fill_n;
                    acc_d       = '0;
                    fill_d      = '0;
                    pend_d      = 1'b0;
                end else if (do_flush) begin
                    pend_d = 1'b1;
                end
            end
        end

        if (emit) out_valid_d = 1'b1;

        if (emit || in_valid) begin
            idle_d = '0;
        end else if ((TIMEOUT > 0) && (fill_q != '0) && !full && (idle_q < 32'(TIMEOUT))) begin
            idle_d = idle_q + 32'd1;
        end

        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            fill_q      <= '0;
            pend_q      <= 1'b0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: three parameterisations share one stimulus stream; the
// default instance is tracked every cycle by a lane-queue reference model.
module tb_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_ovf = 1'b0;

    logic        a_ov, b_ov, c_ov;
    logic [31:0] a_od, b_od, c_od;
    logic [2:0]  a_oc, b_oc, c_oc;
    logic        a_ovf, b_ovf, c_ovf;
    logic [15:0] a_dc, b_dc, c_dc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    word_packer u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_count(a_oc),
        .overflow(a_ovf), .drop_cnt(a_dc), .clr_ovf(clr_ovf)
    );

    word_packer #(.MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_count(b_oc),
        .overflow(b_ovf), .drop_cnt(b_dc), .clr_ovf(clr_ovf)
    );

    word_packer #(.TIMEOUT(5)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .out_count(c_oc),
        .overflow(c_ovf), .drop_cnt(c_dc), .clr_ovf(clr_ovf)
    );

    // Reference model for u_a: accumulator is a queue of lanes, output is one register.
    int          acc[$];
    bit          m_ov;
    logic [31:0] m_data;
    int          m_cnt;
    bit          m_pend;
    bit          m_ovf;
    int          m_drops;
    logic [34:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc.delete();
        exp_q.delete();
        m_ov = 0; m_data = '0; m_cnt = 0; m_pend = 0; m_ovf = 0; m_drops = 0;
    endtask

    task automatic model_emit();
        logic [31:0] w;
        w = '0;
        foreach (acc[k]) w[k*8 +: 8] = acc[k][7:0];
        m_ov = 1; m_data = w; m_cnt = acc.size();
        exp_q.push_back({3'(m_cnt), w});
        acc.delete();
    endtask

    task automatic model_step();
        bit free, doflush, dropped;
        free = !m_ov || out_ready;
        dropped = 0;
        if (m_ov && out_ready) m_ov = 0;
        if (acc.size() == 4) begin
            if (free) begin
                model_emit();
                if (in_valid) acc.push_back(int'(in_data));
                m_pend = flush && in_valid;
            end else begin
                dropped = in_valid;
                if (flush) m_pend = 1;
            end
        end else begin
            if (in_valid) acc.push_back(int'(in_data));
            doflush = flush || m_pend;
            if (acc.size() > 0 && (acc.size() == 4 || doflush)) begin
                if (free) begin model_emit(); m_pend = 0; end
                else if (doflush) m_pend = 1;
            end
        end
        if (clr_ovf) begin m_ovf = 0; m_drops = 0; end
        else if (dropped) begin m_ovf = 1; if (m_drops < 65535) m_drops++; end
    endtask

    // One clock: scoreboard the pre-edge handshake, advance the model, compare after the edge.
    task automatic tick();
        logic [34:0] e;
        if (a_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(a_od), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'(a_od), 64'(e[31:0]));
                chk("sb_count", 64'(a_oc), 64'(e[34:32]));
            end
        end
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", 64'(a_ov), 64'(m_ov));
        if (m_ov) begin
            chk("out_data", 64'(a_od), 64'(m_data));
            chk("out_count", 64'(a_oc), 64'(m_cnt));
        end
        chk("overflow", 64'(a_ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(a_dc), 64'(m_drops));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst_a_valid", 64'(a_ov), 0);
        chk("rst_a_data", 64'(a_od), 0);
        chk("rst_a_count", 64'(a_oc), 0);
        chk("rst_a_ovf", 64'(a_ovf), 0);
        chk("rst_a_drop", 64'(a_dc), 0);
        chk("rst_b_data", 64'(b_od), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic lane(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Default and MSB-first packing.
        out_ready = 1'b1;
        lane(8'h11); lane(8'h22); lane(8'h33); lane(8'h44);
        chk("t1_a_valid", 64'(a_ov), 1);
        chk("t1_a_data", 64'(a_od), 64'h44332211);
        chk("t1_a_count", 64'(a_oc), 4);
        chk("t1_b_data", 64'(b_od), 64'h11223344);
        tick();
        chk("t1_one_cycle", 64'(a_ov), 0);

        // Flush with a same-cycle lane.
        lane(8'hAA); lane(8'hBB);
        flush = 1'b1;
        lane(8'hCC);
        flush = 1'b0;
        chk("t2_a_data", 64'(a_od), 64'h00CCBBAA);
        chk("t2_a_count", 64'(a_oc), 3);
        chk("t2_b_data", 64'(b_od), 64'hAABBCC00);
        tick();

        // Backpressure: two words held, ninth lane dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) lane(8'(i));
        chk("t3_ovf", 64'(a_ovf), 1);
        chk("t3_drop", 64'(a_dc), 1);
        chk("t3_held", 64'(a_od), 64'h04030201);
        out_ready = 1'b1;
        tick();
        chk("t3_second", 64'(a_od), 64'h08070605);
        chk("t3_second_v", 64'(a_ov), 1);
        tick();
        chk("t3_drained", 64'(a_ov), 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_clr_ovf", 64'(a_ovf), 0);
        chk("t3_clr_drop", 64'(a_dc), 0);

        // Reset mid-word discards the partial word.
        lane(8'hE1); lane(8'hE2);
        do_reset();
        for (int i = 1; i <= 4; i++) lane(8'(i));
        chk("t4_data", 64'(a_od), 64'h04030201);
        chk("t4_count", 64'(a_oc), 4);
        tick();
        chk("t4_no_extra", 64'(exp_q.size()), 0);

        // Idle timeout on the TIMEOUT=5 instance.
        do_reset();
        lane(8'h5A);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_not_yet", 64'(c_ov), 0);
        tick();
        chk("t5_valid", 64'(c_ov), 1);
        chk("t5_data", 64'(c_od), 64'h0000005A);
        chk("t5_count", 64'(c_oc), 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("final_exp_q_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
